inst_fetch: RTL and testbench

//  Instruction fetch unit: the PC-driving side of the instruction ROM interface.

---
 rtl/inst_fetch.sv | 158 +++++++++++++++
 tb/tb_inst_fetch.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: PC generator and 2-entry fetch queue feeding decode.
// Handles redirects (queue flush) and stops fetching at the HALT encoding.
module inst_fetch #(
  parameter int                 PC_W       = 16,
  parameter int                 INST_W     = 9,
  parameter logic [PC_W-1:0]    START_ADDR = '0,
  parameter logic [INST_W-1:0]  HALT_INST  = '1
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              start,
  output logic [PC_W-1:0]   PC,
  input  logic [INST_W-1:0] inst_in,
  input  logic              branch_en,
  input  logic [PC_W-1:0]   branch_target,
  output logic [INST_W-1:0] inst_out,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_W-1:0]     r_pc;
  logic [PC_W-1:0]     w_pc_nxt;
  logic [1:0]          r_count;
  logic [INST_W-1:0]   r_q0_inst;
  logic [PC_W-1:0]     r_q0_pc;
  logic [INST_W-1:0]   r_q1_inst;
  logic [PC_W-1:0]     r_q1_pc;

  logic                w_pop;
  logic                w_push;
  logic                w_flush;
  logic                w_active;
  logic                w_redirect;
  logic                w_halt_pop;

  assign PC         = r_pc;
  assign inst_out   = r_q0_inst;
  assign inst_pc    = r_q0_pc;
  assign inst_valid = (r_count != 2'd0);
  assign halted     = (r_state == S_HALTED);

  // Handshake decode, next state and next PC
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_active    = (r_state == S_FETCH) | (r_state == S_DRAIN);
    w_pop       = inst_valid & inst_ready;
    w_redirect  = branch_en & w_active;
    w_halt_pop  = w_pop & (r_q0_inst == HALT_INST);
    w_push      = 1'b0;
    w_flush     = 1'b0;
    unique case (r_state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = START_ADDR;
        end
      end
      S_FETCH, S_DRAIN: begin
        if (w_redirect) begin
          w_flush     = 1'b1;
          w_state_nxt = S_FETCH;
          w_pc_nxt    = branch_target;
        end else if (w_halt_pop) begin
          w_flush     = 1'b1;
          w_state_nxt = S_HALTED;
        end else if (r_state == S_FETCH) begin
          w_push = (r_count != 2'd2) | w_pop;
          if (w_push) begin
            w_pc_nxt = r_pc + 1'b1;
            if (inst_in == HALT_INST) begin
              w_state_nxt = S_DRAIN;
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Program counter
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      r_pc <= START_ADDR;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  // Queue: q0 is the head; data is held when the queue empties
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      r_count   <= 2'd0;
      r_q0_inst <= '0;
      r_q0_pc   <= '0;
      r_q1_inst <= '0;
      r_q1_pc   <= '0;
    end else if (w_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b11: begin
          if (r_count == 2'd2) begin
            r_q0_inst <= r_q1_inst;
            r_q0_pc   <= r_q1_pc;
            r_q1_inst <= inst_in;
            r_q1_pc   <= r_pc;
          end else begin
            r_q0_inst <= inst_in;
            r_q0_pc   <= r_pc;
          end
        end
        2'b10: begin
          if (r_count == 2'd0) begin
            r_q0_inst <= inst_in;
            r_q0_pc   <= r_pc;
          end else begin
            r_q1_inst <= inst_in;
            r_q1_pc   <= r_pc;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2) begin
            r_q0_inst <= r_q1_inst;
            r_q0_pc   <= r_q1_pc;
          end
          r_count <= r_count - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and random checks of inst_fetch
// against a queue-based reference model of the fetch unit.
module tb_inst_fetch;

  localparam logic [8:0]  HALT  = 9'h1FF;
  localparam logic [15:0] START = 16'h0000;
  localparam int M_IDLE   = 0;
  localparam int M_FETCH  = 1;
  localparam int M_DRAIN  = 2;
  localparam int M_HALTED = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] PC;
  logic [8:0]  inst_in;
  logic        branch_en = 1'b0;
  logic [15:0] branch_target = 16'h0;
  logic [8:0]  inst_out;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        halted;

  logic [8:0]  rom [65536];

  int total = 0;
  int bad   = 0;

  int          m_state = M_IDLE;
  logic [15:0] m_pc = START;
  logic [24:0] mq [$];
  logic [24:0] m_last = '0;

  inst_fetch dut (
    .CLK(clk),
    .Reset_n(rst_n),
    .start(start),
    .PC(PC),
    .inst_in(inst_in),
    .branch_en(branch_en),
    .branch_target(branch_target),
    .inst_out(inst_out),
    .inst_pc(inst_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .halted(halted)
  );

  always #5 clk = ~clk;

  assign inst_in = rom[PC];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [8:0] w;
    bit         pop;
    w = rom[m_pc];
    if (!rst_n) begin
      m_state = M_IDLE;
      m_pc    = START;
      mq.delete();
      m_last  = '0;
    end else if (m_state == M_IDLE || m_state == M_HALTED) begin
      if (start) begin
        m_state = M_FETCH;
        m_pc    = START;
      end
    end else begin
      pop = (mq.size() > 0) && inst_ready;
      if (branch_en) begin
        mq.delete();
        m_pc    = branch_target;
        m_state = M_FETCH;
      end else if (pop && mq[0][8:0] == HALT) begin
        mq.delete();
        m_state = M_HALTED;
      end else begin
        if (pop) void'(mq.pop_front());
        if (m_state == M_FETCH && mq.size() < 2) begin
          mq.push_back({m_pc, w});
          m_pc = m_pc + 16'd1;
          if (w == HALT) m_state = M_DRAIN;
        end
      end
    end
    if (mq.size() > 0) m_last = mq[0];
  endtask

  task automatic step(input logic s, input logic br,
                      input logic [15:0] tgt, input logic rdy,
                      input logic rn);
    start         = s;
    branch_en     = br;
    branch_target = tgt;
    inst_ready    = rdy;
    rst_n         = rn;
    model_step();
    @(posedge clk);
    #1;
    chk("pc", {16'h0, PC}, {16'h0, m_pc});
    chk("valid", {31'h0, inst_valid}, {31'h0, mq.size() > 0});
    chk("inst_out", {23'h0, inst_out}, {23'h0, m_last[8:0]});
    chk("inst_pc", {16'h0, inst_pc}, {16'h0, m_last[24:9]});
    chk("halted", {31'h0, halted}, {31'h0, m_state == M_HALTED});
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [8:0] v;
    for (int i = 0; i < 65536; i++) begin
      v = 9'($urandom_range(0, 510));
      rom[i] = ($urandom_range(0, 15) == 0) ? HALT : v;
    end
    rom[0] = 9'h012;
    rom[1] = 9'h034;
    rom[2] = 9'h056;
    rom[3] = HALT;
    rom[16'h0040] = 9'h0C3;
    rom[16'h0041] = 9'h0C4;
    rom[16'hFFFF] = 9'h0AA;
    rom[16'h0100] = 9'h101;
    rom[16'h0101] = 9'h102;
    rom[16'h0102] = 9'h103;
    rom[16'h0103] = 9'h104;
    rom[16'h0104] = HALT;

    // reset state
    do_reset();
    chk("rst_pc", {16'h0, PC}, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_out", {23'h0, inst_out}, 32'h0);

    // 1: straight-line run to HALT
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    chk("t1_halted", {31'h0, halted}, 32'h1);
    chk("t1_pc", {16'h0, PC}, 32'h4);

    // 2: back-pressure then release
    do_reset();
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("t2_pc", {16'h0, PC}, 32'h2);
    chk("t2_out", {23'h0, inst_out}, 32'h012);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    chk("t2_halted", {31'h0, halted}, 32'h1);

    // 3: redirect with two entries queued
    do_reset();
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h0040, 1'b0, 1'b1);
    chk("t3_flush", {31'h0, inst_valid}, 32'h0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    chk("t3_pc40", {16'h0, inst_pc}, 32'h0040);
    chk("t3_inst", {23'h0, inst_out}, 32'h0C3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

    // 4: PC wrap
    step(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    chk("t4_ffff", {16'h0, inst_pc}, 32'hFFFF);
    chk("t4_wrap", {16'h0, PC}, 32'h0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    chk("t4_0000", {16'h0, inst_pc}, 32'h0);

    // 5: reset mid-fetch with two queued
    step(1'b0, 1'b1, 16'h0040, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("t5_pc", {16'h0, PC}, 32'h0);
    chk("t5_valid", {31'h0, inst_valid}, 32'h0);
    chk("t5_halted", {31'h0, halted}, 32'h0);

    // 6: redirect beats HALT pop; restart after halt
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (mq.size() > 0 && mq[0][8:0] == HALT) break;
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    end
    chk("t6_halt_at_head", {23'h0, inst_out}, {23'h0, HALT});
    step(1'b0, 1'b1, 16'h0100, 1'b1, 1'b1);
    chk("t6_no_halt", {31'h0, halted}, 32'h0);
    chk("t6_pc", {16'h0, PC}, 32'h0100);
    for (int i = 0; i < 20; i++) begin
      if (m_state == M_HALTED) break;
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    end
    chk("t6_halted", {31'h0, halted}, 32'h1);
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    chk("t6_restart_pc", {16'h0, PC}, 32'h0);
    chk("t6_restart_h", {31'h0, halted}, 32'h0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    chk("t6_refetch", {23'h0, inst_out}, 32'h012);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 9) == 0),
           16'($urandom),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 63) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
